// File: rtl/inv_sub_bytes_iter.sv
// rtl/inv_sub_bytes_iter.sv - AES InvSubBytes over a 128-bit state, one 32-bit column per cycle.
// Define INV_SUB_BYTES_FAST_EN for a 16-lookup, single-step variant.
module inv_sub_bytes_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] in_q, in_d;
    logic [127:0] res_q, res_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic         busy_q, busy_d;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] s;
        s = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(s);
    endfunction

`ifdef INV_SUB_BYTES_FAST_EN
    logic [127:0] full_out;

    for (genvar g = 0; g < 16; g++) begin : g_lut
        assign full_out[127-8*g -: 8] = inv_sbox(in_state[127-8*g -: 8]);
    end
`else
    logic [31:0] col_in;
    logic [31:0] col_out;

    always_comb begin
        col_in = in_q[127:96];
        case (col_q)
            2'd0:    col_in = in_q[127:96];
            2'd1:    col_in = in_q[95:64];
            2'd2:    col_in = in_q[63:32];
            default: col_in = in_q[31:0];
        endcase
    end

    for (genvar g = 0; g < 4; g++) begin : g_lut
        assign col_out[31-8*g -: 8] = inv_sbox(col_in[31-8*g -: 8]);
    end
`endif

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        in_d    = in_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    in_d  = in_state;
                    col_d = 2'd0;
`ifdef INV_SUB_BYTES_FAST_EN
                    res_d   = full_out;
                    state_d = DONE;
`else
                    state_d = BUSY;
`endif
                end
            end
            BUSY: begin
`ifdef INV_SUB_BYTES_FAST_EN
                state_d = DONE;
`else
                case (col_q)
                    2'd0:    res_d[127:96] = col_out;
                    2'd1:    res_d[95:64]  = col_out;
                    2'd2:    res_d[63:32]  = col_out;
                    default: res_d[31:0]   = col_out;
                endcase
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) state_d = DONE;
`endif
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Handshake outputs are registered from the next state so they stay low in reset.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= 2'd0;
            in_q        <= 128'h0;
            res_q       <= 128'h0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            in_q        <= in_d;
            res_q       <= res_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_state = res_q;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// tb/tb_inv_sub_bytes_iter.sv - self-checking bench for inv_sub_bytes_iter.
module tb_inv_sub_bytes_iter;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

`ifdef INV_SUB_BYTES_FAST_EN
    localparam int EXP_LAT = 0;
`else
    localparam int EXP_LAT = 4;
`endif

    int n_tests;
    int n_fail;
    logic [7:0] sbox_tab [256];
    logic [7:0] inv_tab  [256];

    inv_sub_bytes_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        int x;
        int y;
        int acc;
        x = a;
        y = b;
        acc = 0;
        while (y != 0) begin
            if (y % 2 == 1) acc = acc ^ x;
            x = x * 2;
            if (x >= 256) x = x ^ 'h11b;
            y = y / 2;
        end
        return acc[7:0];
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] b;
        logic [7:0] f;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (ref_mul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
            b = inv;
            f = b ^ ((b << 1) | (b >> 7)) ^ ((b << 2) | (b >> 6))
                  ^ ((b << 3) | (b >> 5)) ^ ((b << 4) | (b >> 4)) ^ 8'h63;
            sbox_tab[x] = f;
            inv_tab[f]  = x[7:0];
        end
    endtask

    function automatic logic [127:0] ref_sub(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = sbox_tab[s[127-8*k -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] ref_inv_sub(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = inv_tab[s[127-8*k -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send(input logic [127:0] d, output int lat, output logic [127:0] res, output bit to);
        int n;
        to  = 1'b0;
        lat = 0;
        res = 128'h0;
        n   = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            to = 1'b1;
            return;
        end
        in_state = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_state = rand128();
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!out_valid) to = 1'b1;
        res = out_state;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({in_ready, out_valid, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000", {in_ready, out_valid, busy});
        end
        n_tests++;
        if (out_state !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_out_state: got %h want 0", out_state);
        end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_known(input string name, input logic [127:0] d, input logic [127:0] exp);
        int lat;
        logic [127:0] res;
        bit to;
        send(d, lat, res, to);
        n_tests++;
        if (to) begin
            n_fail++;
            $display("FAIL %s_timeout: handshake did not complete", name);
        end
        n_tests++;
        if (lat != EXP_LAT) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d want %0d", name, lat, EXP_LAT);
        end
        n_tests++;
        if (res !== exp || res !== ref_inv_sub(d)) begin
            n_fail++;
            $display("FAIL %s_data: got %h want %h", name, res, exp);
        end
        release_out();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [127:0] res;
        logic [127:0] d;
        logic [127:0] exp;
        bit to;
        d   = rand128();
        exp = ref_inv_sub(d);
        send(d, lat, res, to);
        n_tests++;
        if (to || res !== exp) begin
            n_fail++;
            $display("FAIL bp_first: got %h want %h timeout %0d", res, exp, to);
        end
        in_valid = 1'b1;
        in_state = rand128();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_tests++;
            if ({out_valid, in_ready, busy} !== 3'b101 || out_state !== exp) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: flags %b data %h want 101 %h", i, {out_valid, in_ready, busy}, out_state, exp);
            end
            in_state = rand128();
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_release: in_ready/out_valid %b want 10", {in_ready, out_valid});
        end
        repeat (6) @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ignored_second: out_valid %b busy %b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_reset_mid_busy();
        int n;
        int seen;
        int lat;
        logic [127:0] res;
        logic [127:0] d;
        bit to;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        in_state = rand128();
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({in_ready, out_valid, busy} !== 3'b000 || out_state !== 128'h0) begin
            n_fail++;
            $display("FAIL midrst_zero: flags %b data %h want 000 0", {in_ready, out_valid, busy}, out_state);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL midrst_no_valid: out_valid seen %0d cycles want 0", seen);
        end
        d = rand128();
        send(d, lat, res, to);
        n_tests++;
        if (to || lat != EXP_LAT || res !== ref_inv_sub(d)) begin
            n_fail++;
            $display("FAIL midrst_next: got %h lat %0d want %h lat %0d", res, lat, ref_inv_sub(d), EXP_LAT);
        end
        release_out();
    endtask

    task automatic test_random_roundtrip();
        int lat;
        int bad;
        logic [127:0] res;
        logic [127:0] x;
        bit to;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            x = rand128();
            send(ref_sub(x), lat, res, to);
            n_tests++;
            if (to || lat != EXP_LAT || res !== x) begin
                n_fail++;
                bad++;
                if (bad <= 5)
                    $display("FAIL roundtrip_%0d: got %h lat %0d want %h lat %0d", i, res, lat, x, EXP_LAT);
            end
            release_out();
            if (to) break;
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [127:0] res;
        logic [127:0] d;
        bit to;
        d = rand128();
        send(d, lat, res, to);
        release_out();
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready: got %b want 1", in_ready);
        end
        d = rand128();
        send(d, lat, res, to);
        n_tests++;
        if (to || res !== ref_inv_sub(d)) begin
            n_fail++;
            $display("FAIL b2b_data: got %h want %h", res, ref_inv_sub(d));
        end
        release_out();
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_state  = 128'h0;
        out_ready = 1'b0;
        build_tables();
        test_reset();
        test_known("k63", {16{8'h63}}, 128'h0);
        test_known("k00", 128'h0, {16{8'h52}});
        test_known("kalt", {8{16'h167C}}, {8{16'hFF01}});
        test_backpressure();
        test_reset_mid_busy();
        test_back_to_back();
        test_random_roundtrip();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
